// File: rtl/feed_forward_inverter_if.sv
// Request/result bundle for feed_forward_inverter: start strobe with gain and value in,
// busy/valid/saturation flags and the signed aim out.
interface feed_forward_inverter_if;
  logic               i_en;
  logic        [15:0] i_Kg;
  logic signed [15:0] i_value;
  logic               o_busy;
  logic               o_en;
  logic               o_sat;
  logic signed [15:0] o_value;

  modport master (
    output i_en, i_Kg, i_value,
    input  o_busy, o_en, o_sat, o_value
  );

  modport slave (
    input  i_en, i_Kg, i_value,
    output o_busy, o_en, o_sat, o_value
  );
endinterface

// File: rtl/feed_forward_inverter.sv
// Inverse feed-forward gain: o_value = (|i_value| << FRAC_BITS) / Kg with sign reapplied,
// computed by a restoring divider. Define FFI_ROUND_EN for round-half-up on the magnitude.
//
// state | meaning
// IDLE  | waiting for i_en; captures sign, magnitude, gain
// DIV   | ITER restoring-divide iterations, one quotient bit per clock
// DONE  | saturate/sign the quotient, register result, pulse o_en
module feed_forward_inverter #(
  parameter int FRAC_BITS = 8
) (
  input  logic clk,
  input  logic rstn,
  feed_forward_inverter_if.slave bus
);
  localparam int ITER = 16 + FRAC_BITS;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t            state;
  logic              sign;
  logic              mag_zero;
  logic              div0;
  logic [16:0]       rem;
  logic [ITER-1:0]   dvd;
  logic [15:0]       divisor;
  logic [CW-1:0]     cnt;

  logic [16:0]       sv_ext;
  logic [16:0]       mag_in;
  logic [ITER-1:0]   dvd_init;
  logic [17:0]       trial;
  logic              ge;
  logic [16:0]       diff;
  logic [15:0]       res_val;
  logic              res_sat;

  always_comb begin
    sv_ext   = {bus.i_value[15], bus.i_value};
    mag_in   = bus.i_value[15] ? (~sv_ext + 17'd1) : sv_ext;
    dvd_init = ITER'(mag_in) << FRAC_BITS;
`ifdef FFI_ROUND_EN
    if (bus.i_Kg != 16'd0)
      dvd_init = dvd_init + ITER'(bus.i_Kg >> 1);
`endif
    trial = {rem, dvd[ITER-1]};
    ge    = trial >= {2'b00, divisor};
    diff  = 17'(trial - {2'b00, divisor});
  end

  // The quotient sits in dvd once all iterations have shifted through it.
  always_comb begin
    res_val = 16'd0;
    res_sat = 1'b0;
    if (div0) begin
      res_sat = 1'b1;
      if (!mag_zero)
        res_val = sign ? 16'h8001 : 16'h7FFF;
    end else if (dvd > ITER'(32767)) begin
      res_sat = 1'b1;
      res_val = sign ? 16'h8001 : 16'h7FFF;
    end else begin
      res_val = sign ? (~dvd[15:0] + 16'd1) : dvd[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      sign        <= 1'b0;
      mag_zero    <= 1'b0;
      div0        <= 1'b0;
      rem         <= '0;
      dvd         <= '0;
      divisor     <= '0;
      cnt         <= '0;
      bus.o_busy  <= 1'b0;
      bus.o_en    <= 1'b0;
      bus.o_sat   <= 1'b0;
      bus.o_value <= '0;
    end else begin
      bus.o_en <= 1'b0;
      case (state)
        IDLE: begin
          bus.o_busy <= 1'b0;
          if (bus.i_en) begin
            sign       <= bus.i_value[15];
            mag_zero   <= (mag_in == 17'd0);
            div0       <= (bus.i_Kg == 16'd0);
            dvd        <= dvd_init;
            divisor    <= bus.i_Kg;
            rem        <= '0;
            cnt        <= CW'(ITER - 1);
            bus.o_busy <= 1'b1;
            state      <= DIV;
          end
        end
        DIV: begin
          rem <= ge ? diff : trial[16:0];
          dvd <= {dvd[ITER-2:0], ge};
          if (cnt == '0)
            state <= DONE;
          else
            cnt <= cnt - 1'b1;
        end
        DONE: begin
          bus.o_value <= res_val;
          bus.o_sat   <= res_sat;
          bus.o_en    <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_feed_forward_inverter.sv
// Scoreboard bench for feed_forward_inverter: driver pushes model results with due cycle,
// monitor pops and compares on every o_en.
module tb_feed_forward_inverter;
  localparam int FB   = 8;
  localparam int ITER = 16 + FB;

  typedef struct {
    int val;
    bit sat;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   bad_busy = 1'b0;
  exp_t exp_q[$];

  feed_forward_inverter_if bus ();

  feed_forward_inverter #(.FRAC_BITS(FB)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void model(input int v, input int kg, output int ev, output bit es);
    longint mag, num, q;
    mag = (v < 0) ? -v : v;
    num = mag * (64'sd1 <<< FB);
`ifdef FFI_ROUND_EN
    if (kg != 0) num = num + kg / 2;
`endif
    if (kg == 0) begin
      es = 1'b1;
      ev = (mag == 0) ? 0 : ((v < 0) ? -32767 : 32767);
    end else begin
      q = num / kg;
      if (q > 32767) begin
        es = 1'b1;
        ev = (v < 0) ? -32767 : 32767;
      end else begin
        es = 1'b0;
        ev = (v < 0) ? -int'(q) : int'(q);
      end
    end
  endfunction

  // Monitor: compares every presented result against the scoreboard head.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (exp_q.size() != 0 && bus.o_busy !== 1'b1 && bus.o_en !== 1'b1)
        bad_busy = 1'b1;
      if (bus.o_en === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_o_en cycle=%0d value=%0d", cyc, $signed(bus.o_value));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ($signed(bus.o_value) != e.val || bus.o_sat !== e.sat || cyc != e.due ||
              bus.o_busy !== 1'b1 || bad_busy) begin
            failures++;
            $display("FAIL result got value=%0d sat=%0b cycle=%0d busy=%0b busy_gap=%0b want value=%0d sat=%0b cycle=%0d busy=1 busy_gap=0",
                     $signed(bus.o_value), bus.o_sat, cyc, bus.o_busy, bad_busy, e.val, e.sat, e.due);
          end
          bad_busy = 1'b0;
        end
      end
    end
  end

  task automatic start(input int v, input int kg, input bit hold);
    int ev;
    bit es;
    exp_t e;
    model(v, kg, ev, es);
    bus.i_value = 16'(v);
    bus.i_Kg    = 16'(kg);
    bus.i_en    = 1'b1;
    @(negedge clk);
    e.val = ev;
    e.sat = es;
    e.due = cyc + ITER + 1;
    exp_q.push_back(e);
    bad_busy = 1'b0;
    if (hold) begin
      bus.i_value = 16'(v + 7);
      repeat (ITER + 1) @(negedge clk);
    end
    bus.i_en = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout outstanding=%0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({bus.o_busy, bus.o_en, bus.o_sat, bus.o_value} !== 19'd0) begin
      failures++;
      $display("FAIL %s got busy=%0b en=%0b sat=%0b value=%0d want all 0",
               name, bus.o_busy, bus.o_en, bus.o_sat, $signed(bus.o_value));
    end
  endtask

  int dir_v[9]  = '{100, -300, 32767, -32768, 5, -5, 0, 1, -1};
  int dir_kg[9] = '{256, 768, 1, 1, 0, 0, 0, 384, 384};

  initial begin
    rstn = 1'b0;
    bus.i_en = 1'b0;
    bus.i_Kg = '0;
    bus.i_value = '0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      start(dir_v[i], dir_kg[i], 1'b0);
      wait_done();
    end

    // Retrigger while busy: only one result may appear.
    start(1234, 300, 1'b1);
    wait_done();
    repeat (5) @(negedge clk);

    // Reset mid-divide aborts with no result.
    start(500, 200, 1'b0);
    repeat (10) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check_zero("reset_abort");
    exp_q.delete();
    rstn = 1'b1;
    repeat (30) @(negedge clk);
    start(-777, 129, 1'b0);
    wait_done();

    for (int i = 0; i < 150; i++) begin
      int v, kg;
      v = int'($signed(16'($urandom)));
      case ($urandom_range(0, 3))
        0: kg = $urandom_range(0, 8);
        1: kg = $urandom_range(0, 1023);
        default: kg = $urandom_range(0, 65535);
      endcase
      start(v, kg, 1'b0);
      wait_done();
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
